// File: rtl/flop_share_arbiter.sv
`default_nettype none
// ============================================================================
// flop_share_arbiter : round-robin owner/sequencer for one shared flipflop reg
// Revision 1.0
// ============================================================================
module flop_share_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int INIT_CYCLES = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       rdata,
  output logic                   busy,
  output logic [WIDTH-1:0]       qin,
  output logic                   ff_reset,
  input  logic [WIDTH-1:0]       qout
);

  localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int ICW = $clog2(INIT_CYCLES + 1);
  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_LOAD = 3'd2,
    S_CAPT = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_own;
  logic [ICW-1:0]   r_icnt;
  logic [HCW-1:0]   r_hcnt;
  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_idx;
  logic             w_found;
  logic             w_own_req;
  logic [N_REQ-1:0] w_own_hot;
  logic [WIDTH-1:0] w_din [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_din[i] = din[i*WIDTH +: WIDTH];
  end

  // Scan starts just after the previous winner, so it has lowest priority.
  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_own_req = req[r_own];
  assign w_own_hot = N_REQ'(1) << r_own;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_INIT;
      r_ptr    <= IW'(N_REQ - 1);
      r_own    <= '0;
      r_icnt   <= '0;
      r_hcnt   <= '0;
      gnt      <= '0;
      done     <= '0;
      rdata    <= '0;
      qin      <= '0;
      busy     <= 1'b1;
      ff_reset <= 1'b1;
    end else begin
      done <= '0;
      case (r_state)
        S_INIT: begin
          if (r_icnt == ICW'(INIT_CYCLES - 1)) begin
            ff_reset <= 1'b0;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_icnt <= r_icnt + ICW'(1);
          end
        end
        S_IDLE: begin
          if (w_found) begin
            gnt     <= N_REQ'(1) << w_win;
            r_own   <= w_win;
            busy    <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!w_own_req) begin
            gnt     <= '0;
            r_ptr   <= r_own;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            qin     <= w_din[r_own];
            r_state <= S_CAPT;
          end
        end
        S_CAPT: begin
          if (!w_own_req) begin
            gnt     <= '0;
            r_ptr   <= r_own;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_hcnt  <= '0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Completion takes precedence over a request drop on the final cycle.
          if (r_hcnt == HCW'(HOLD_CYCLES - 1)) begin
            rdata   <= qout;
            done    <= w_own_hot;
            gnt     <= '0;
            r_ptr   <= r_own;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (!w_own_req) begin
            gnt     <= '0;
            r_ptr   <= r_own;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            rdata  <= qout;
            r_hcnt <= r_hcnt + HCW'(1);
          end
        end
        default: begin
          gnt     <= '0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flop_share_arbiter.sv
`default_nettype none
// Bench for flop_share_arbiter: behavioural flipflop on qin/qout plus a
// scoreboard of expected (owner, data) completions.
module tb_flop_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
  } exp_t;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] din   = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   rdata;
  logic           busy;
  logic [W-1:0]   qin;
  logic           ff_reset;
  logic [W-1:0]   qout;

  exp_t         sb[$];
  int           checks   = 0;
  int           failures = 0;
  logic [N-1:0] gnt_seen = '0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) qout <= ff_reset ? '0 : qin;

  flop_share_arbiter #(
    .N_REQ(N), .WIDTH(W), .INIT_CYCLES(3), .HOLD_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt), .done(done),
    .rdata(rdata), .busy(busy), .qin(qin), .ff_reset(ff_reset), .qout(qout)
  );

  function automatic void push_exp(input int idx, input logic [W-1:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb.push_back(e);
  endfunction

  task automatic wait_done(output int idx, output logic [W-1:0] rd,
                           output int cyc, output bit ok);
    idx = -1; rd = '0; cyc = 0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      gnt_seen |= gnt;
      if (done != '0) begin
        ok = 1'b1;
        rd = rdata;
        for (int j = 0; j < N; j++) if (done[j]) idx = j;
      end
    end
  endtask

  task automatic wait_gnt(output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int idx, cyc; bit ok; logic [W-1:0] rd; exp_t e; logic [N-1:0] eh;
    reset = 1'b0; req = 4'b0001; din[0*W +: W] = 8'h3C;
    repeat (2) @(negedge clk);
    checks++;
    if (ff_reset !== 1'b1 || busy !== 1'b1 || gnt !== '0 || done !== '0 || rdata !== '0 || qin !== '0) begin
      failures++;
      $display("FAIL reset_values: ff_reset=%b busy=%b gnt=%b done=%b rdata=%h qin=%h required 1 1 0000 0000 00 00",
               ff_reset, busy, gnt, done, rdata, qin);
    end
    reset = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (ff_reset !== (c < 3) || busy !== (c < 3) || gnt !== '0) begin
        failures++;
        $display("FAIL init_seq c%0d: ff_reset=%b busy=%b gnt=%b required ff_reset=%b busy=%b gnt=0000",
                 c, ff_reset, busy, gnt, c < 3, c < 3);
      end
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL first_grant: gnt=%b busy=%b required gnt=0001 busy=1", gnt, busy);
    end
    push_exp(0, 8'h3C);
    wait_done(idx, rd, cyc, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL reset_done: done_seen=%0d pending=%0d required a done with a pending entry", ok, sb.size());
    end else begin
      e = sb.pop_front(); eh = N'(1) << e.idx;
      if (done !== eh || rd !== e.data) begin
        failures++;
        $display("FAIL reset_done: done=%b rdata=%h required done=%b rdata=%h", done, rd, eh, e.data);
      end
    end
    req = '0;
  endtask

  task automatic test_single();
    int idx, cyc; bit ok; logic [W-1:0] rd; exp_t e; logic [N-1:0] eh;
    req = 4'b0100; din[2*W +: W] = 8'hA5;
    push_exp(2, 8'hA5);
    wait_gnt(cyc, ok);
    checks++;
    if (!ok || gnt !== 4'b0100) begin
      failures++;
      $display("FAIL single_gnt: gnt=%b required 0100", gnt);
    end
    @(negedge clk);
    checks++;
    if (qin !== 8'hA5) begin
      failures++;
      $display("FAIL single_qin: qin=%h required a5", qin);
    end
    wait_done(idx, rd, cyc, ok);
    checks++;
    if (!ok || sb.size() == 0 || cyc + 1 != 4) begin
      failures++;
      $display("FAIL single_latency: done_seen=%0d latency=%0d required 4", ok, cyc + 1);
    end else begin
      e = sb.pop_front(); eh = N'(1) << e.idx;
      checks++;
      if (done !== eh || rd !== e.data || gnt !== '0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL single_done: done=%b rdata=%h gnt=%b busy=%b required done=%b rdata=%h gnt=0000 busy=0",
                 done, rd, gnt, busy, eh, e.data);
      end
    end
    req = '0;
  endtask

  task automatic test_round_robin(inout int ptr);
    int idx, cyc; bit ok; logic [W-1:0] rd; exp_t e; logic [N-1:0] eh;
    for (int i = 0; i < N; i++) din[i*W +: W] = W'(i + 1);
    for (int k = 0; k < 5; k++) begin
      ptr = (ptr + 1) % N;
      push_exp(ptr, W'(ptr + 1));
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(idx, rd, cyc, ok);
      checks++;
      if (!ok || sb.size() == 0) begin
        failures++;
        $display("FAIL rr_done%0d: done_seen=%0d pending=%0d required a done with a pending entry", k, ok, sb.size());
      end else begin
        e = sb.pop_front(); eh = N'(1) << e.idx;
        if (done !== eh || rd !== e.data) begin
          failures++;
          $display("FAIL rr_done%0d: done=%b rdata=%h required done=%b rdata=%h", k, done, rd, eh, e.data);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_abort();
    int idx, cyc; bit ok; logic [W-1:0] rd; exp_t e; logic [N-1:0] eh;
    req = 4'b0010; din[1*W +: W] = 8'h11; din[2*W +: W] = 8'h22;
    wait_gnt(cyc, ok);
    checks++;
    if (!ok || gnt !== 4'b0010) begin
      failures++;
      $display("FAIL abort_gnt: gnt=%b required 0010", gnt);
    end
    req = 4'b0110;
    repeat (2) @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || done !== '0) begin
      failures++;
      $display("FAIL abort_drop: gnt=%b done=%b required gnt=0000 done=0000", gnt, done);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL abort_next: gnt=%b required 0100", gnt);
    end
    push_exp(2, 8'h22);
    wait_done(idx, rd, cyc, ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      failures++;
      $display("FAIL abort_done: done_seen=%0d pending=%0d required a done with a pending entry", ok, sb.size());
    end else begin
      e = sb.pop_front(); eh = N'(1) << e.idx;
      if (done !== eh || rd !== e.data) begin
        failures++;
        $display("FAIL abort_done: done=%b rdata=%h required done=%b rdata=%h", done, rd, eh, e.data);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_midop();
    int idx, cyc; bit ok; logic [W-1:0] rd; exp_t e; logic [N-1:0] eh;
    req = 4'b1000; din[3*W +: W] = 8'h77; din[0*W +: W] = 8'h55;
    wait_gnt(cyc, ok);
    @(negedge clk);
    reset = 1'b0; req = 4'b1001;
    #1;
    checks++;
    if (gnt !== '0 || busy !== 1'b1 || ff_reset !== 1'b1 || done !== '0) begin
      failures++;
      $display("FAIL midop_reset: gnt=%b busy=%b ff_reset=%b done=%b required 0000 1 1 0000", gnt, busy, ff_reset, done);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_gnt(cyc, ok);
    checks++;
    if (!ok || gnt !== 4'b0001 || cyc != 4) begin
      failures++;
      $display("FAIL midop_regrant: gnt=%b after %0d cycles required 0001 after 4", gnt, cyc);
    end
    push_exp(0, 8'h55);
    for (int k = 0; k < 2; k++) begin
      wait_done(idx, rd, cyc, ok);
      checks++;
      if (!ok || sb.size() == 0) begin
        failures++;
        $display("FAIL midop_done%0d: done_seen=%0d pending=%0d required a done with a pending entry", k, ok, sb.size());
      end else begin
        e = sb.pop_front(); eh = N'(1) << e.idx;
        if (done !== eh || rd !== e.data) begin
          failures++;
          $display("FAIL midop_done%0d: done=%b rdata=%h required done=%b rdata=%h", k, done, rd, eh, e.data);
        end
      end
      req = 4'b1000;
      if (k == 0) push_exp(3, 8'h77);
    end
    req = '0;
  endtask

  task automatic test_single_repeat();
    int idx, cyc; bit ok; logic [W-1:0] rd; exp_t e; logic [N-1:0] eh;
    gnt_seen = '0;
    din[0*W +: W] = 8'h00;
    for (int i = 0; i < 8; i++) push_exp(0, W'(i));
    req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      wait_done(idx, rd, cyc, ok);
      checks++;
      if (!ok || sb.size() == 0) begin
        failures++;
        $display("FAIL repeat_done%0d: done_seen=%0d pending=%0d required a done with a pending entry", i, ok, sb.size());
      end else begin
        e = sb.pop_front(); eh = N'(1) << e.idx;
        if (done !== eh || rd !== e.data) begin
          failures++;
          $display("FAIL repeat_done%0d: done=%b rdata=%h required done=%b rdata=%h", i, done, rd, eh, e.data);
        end
      end
      din[0*W +: W] = W'(i + 1);
    end
    req = '0;
    checks++;
    if (gnt_seen !== 4'b0001) begin
      failures++;
      $display("FAIL repeat_gnt_set: grants seen=%b required 0001", gnt_seen);
    end
  endtask

  initial begin
    int ptr;
    test_reset();
    test_single();
    ptr = 2;
    test_round_robin(ptr);
    test_abort();
    test_reset_midop();
    test_single_repeat();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL final_idle: pending=%0d busy=%b required 0 0", sb.size(), busy);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
